// File: rtl/branch_resolve.sv
// branch_resolve
//   Resolves conditional branches from the ALU zero flag. For each accepted
//   request it computes the taken decision and the branch target, then holds
//   the result in a two-entry queue that feeds the PC/fetch stage. After a
//   taken result is handed to fetch, flush pulses for one cycle and
//   taken_count advances. taken_count wraps and exists for debug.
//
// Ports
//   clk, reset               rising-edge clock, synchronous active-high reset
//   in_valid / in_ready      request handshake
//   zero, branch_type        ALU zero flag; 00 none, 01 BEQ, 10 BNE, 11 reserved
//   pc, imm                  branch PC and signed 16-bit word offset
//   out_valid / out_ready    result handshake for the head entry
//   taken, target, next_pc   head entry fields, forced to 0 while the queue is empty
//   flush                    one-cycle pulse after a taken result is delivered
//   taken_count              wrapping count of taken results delivered
//
// state | meaning
// EMPTY | no results queued
// ONE   | head entry valid, tail slot free
// TWO   | both slots full, head in slot 0; in_ready is low
module branch_resolve #(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        zero,
   input  logic [1:0]  branch_type,
   input  logic [31:0] pc,
   input  logic [15:0] imm,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        taken,
   output logic [31:0] target,
   output logic [31:0] next_pc,
   output logic        flush,
   output logic [31:0] taken_count
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   typedef struct packed {
      logic        taken;
      logic [31:0] target;
      logic [31:0] next_pc;
   } entry_t;

   state_t      state_q, state_d;
   entry_t      slot0_q, slot0_d;   // always the head when the queue is non-empty
   entry_t      slot1_q, slot1_d;
   logic        flush_q, flush_d;
   logic [31:0] taken_count_q, taken_count_d;

   logic        push;
   logic        pop;
   logic [31:0] seq_pc;
   logic [31:0] imm_off;
   entry_t      new_e;

   // The queue state doubles as the fill count.
   assign in_ready  = (int'(state_q) < DEPTH);
   assign out_valid = (state_q != EMPTY);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   // Sign-extended word offset, already scaled to bytes.
   assign imm_off = {{14{imm[15]}}, imm, 2'b00};
   assign seq_pc  = pc + 32'd4;

   always_comb begin
      new_e         = '0;
      new_e.target  = seq_pc + imm_off;
      new_e.taken   = ((branch_type == 2'b01) & zero) | ((branch_type == 2'b10) & ~zero);
      new_e.next_pc = new_e.taken ? new_e.target : seq_pc;
   end

   always_comb begin
      state_d = state_q;
      slot0_d = slot0_q;
      slot1_d = slot1_q;
      case (state_q)
         EMPTY: begin
            if (push) begin
               slot0_d = new_e;
               state_d = ONE;
            end
         end
         ONE: begin
            if (push && pop) begin
               slot0_d = new_e;
            end else if (push) begin
               slot1_d = new_e;
               state_d = TWO;
            end else if (pop) begin
               state_d = EMPTY;
            end
         end
         TWO: begin
            if (pop) begin
               slot0_d = slot1_q;
               state_d = ONE;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   always_comb begin
      flush_d       = pop & slot0_q.taken;
      taken_count_d = taken_count_q + {31'd0, flush_d};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= EMPTY;
         slot0_q       <= '0;
         slot1_q       <= '0;
         flush_q       <= 1'b0;
         taken_count_q <= '0;
      end else begin
         state_q       <= state_d;
         slot0_q       <= slot0_d;
         slot1_q       <= slot1_d;
         flush_q       <= flush_d;
         taken_count_q <= taken_count_d;
      end
   end

   assign taken       = out_valid & slot0_q.taken;
   assign target      = out_valid ? slot0_q.target  : 32'd0;
   assign next_pc     = out_valid ? slot0_q.next_pc : 32'd0;
   assign flush       = flush_q;
   assign taken_count = taken_count_q;

endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve
//   Directed vector table, hand-written corner sequences and a random run,
//   all scored against a queue-based reference model of branch_resolve.
module tb_branch_resolve;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic        zero;
   logic [1:0]  branch_type;
   logic [31:0] pc;
   logic [15:0] imm;
   logic        out_valid;
   logic        out_ready;
   logic        taken;
   logic [31:0] target;
   logic [31:0] next_pc;
   logic        flush;
   logic [31:0] taken_count;

   branch_resolve #(.DEPTH(2)) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .zero        (zero),
      .branch_type (branch_type),
      .pc          (pc),
      .imm         (imm),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .taken       (taken),
      .target      (target),
      .next_pc     (next_pc),
      .flush       (flush),
      .taken_count (taken_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        taken;
      logic [31:0] target;
      logic [31:0] next_pc;
   } res_t;

   typedef struct {
      logic        z;
      logic [1:0]  bt;
      logic [31:0] pc;
      logic [15:0] imm;
      logic        taken;
      logic [31:0] target;
      logic [31:0] next_pc;
   } vec_t;

   res_t        mq[$];
   logic        m_flush;
   logic [31:0] m_cnt;
   bit          chk_en;
   int          tests;
   int          fails;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic res_t model(input logic z, input logic [1:0] bt,
                                  input logic [31:0] p, input logic [15:0] im);
      res_t r;
      int   off;
      off       = int'($signed(im));
      r.target  = p + 32'd4 + 32'(off * 4);
      r.taken   = (bt == 2'b01 && z) || (bt == 2'b10 && !z);
      r.next_pc = r.taken ? r.target : p + 32'd4;
      return r;
   endfunction

   task automatic check_outputs();
      res_t h;
      h = '0;
      if (mq.size() != 0) h = mq[0];
      chk("in_ready",    {31'd0, in_ready},  (mq.size() < 2)  ? 32'd1 : 32'd0);
      chk("out_valid",   {31'd0, out_valid}, (mq.size() != 0) ? 32'd1 : 32'd0);
      chk("taken",       {31'd0, taken},     {31'd0, h.taken});
      chk("target",      target,             h.target);
      chk("next_pc",     next_pc,            h.next_pc);
      chk("flush",       {31'd0, flush},     {31'd0, m_flush});
      chk("taken_count", taken_count,        m_cnt);
   endtask

   // Score current outputs, clock once, advance the model. acc reports
   // whether the model saw a request accepted on this edge.
   task automatic tick(output bit acc);
      bit   pop;
      res_t h;
      if (chk_en) check_outputs();
      acc = !reset && in_valid && (mq.size() < 2);
      pop = !reset && out_ready && (mq.size() != 0);
      @(posedge clk);
      if (reset) begin
         mq.delete();
         m_flush = 1'b0;
         m_cnt   = 32'd0;
      end else begin
         m_flush = 1'b0;
         if (pop) begin
            h = mq.pop_front();
            if (h.taken) begin
               m_flush = 1'b1;
               m_cnt   = m_cnt + 32'd1;
            end
         end
         if (acc) mq.push_back(model(zero, branch_type, pc, imm));
      end
      #1;
   endtask

   task automatic step();
      bit dummy;
      tick(dummy);
   endtask

   task automatic set_req(input logic z, input logic [1:0] bt,
                          input logic [31:0] p, input logic [15:0] im);
      zero        = z;
      branch_type = bt;
      pc          = p;
      imm         = im;
   endtask

   task automatic set_rand_req();
      set_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              {$urandom_range(0, 32'hFFFF_FFFF)} & 32'hFFFF_FFFC, 16'($urandom_range(0, 16'hFFFF)));
   endtask

   vec_t vecs[7];

   initial begin
      bit acc;
      int waited;
      int n_acc;

      vecs[0] = '{1'b1, 2'b01, 32'h0000_0100, 16'h0004, 1'b1, 32'h0000_0114, 32'h0000_0114};
      vecs[1] = '{1'b1, 2'b10, 32'h0000_0200, 16'hFFFF, 1'b0, 32'h0000_0200, 32'h0000_0204};
      vecs[2] = '{1'b1, 2'b01, 32'hFFFF_FFFC, 16'h0001, 1'b1, 32'h0000_0004, 32'h0000_0004};
      vecs[3] = '{1'b1, 2'b11, 32'h0000_1000, 16'h0010, 1'b0, 32'h0000_1044, 32'h0000_1004};
      vecs[4] = '{1'b0, 2'b10, 32'h0000_3000, 16'h8000, 1'b1, 32'hFFFE_3004, 32'hFFFE_3004};
      vecs[5] = '{1'b0, 2'b01, 32'h0000_0040, 16'h0002, 1'b0, 32'h0000_004C, 32'h0000_0044};
      vecs[6] = '{1'b1, 2'b00, 32'h0000_0080, 16'h0000, 1'b0, 32'h0000_0084, 32'h0000_0084};

      tests     = 0;
      fails     = 0;
      chk_en    = 1'b0;
      m_flush   = 1'b0;
      m_cnt     = 32'd0;
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      set_req(1'b0, 2'b00, 32'd0, 16'd0);
      #1;
      step();
      step();
      reset  = 1'b0;
      chk_en = 1'b1;

      // Reset state with hard constants.
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
      chk("rst_count",     taken_count,        32'd0);

      // Directed vectors: accept, inspect head one cycle later, deliver, check flush.
      foreach (vecs[i]) begin
         set_req(vecs[i].z, vecs[i].bt, vecs[i].pc, vecs[i].imm);
         in_valid  = 1'b1;
         out_ready = 1'b1;
         step();
         in_valid = 1'b0;
         chk($sformatf("vec%0d_valid", i),   {31'd0, out_valid}, 32'd1);
         chk($sformatf("vec%0d_taken", i),   {31'd0, taken},     {31'd0, vecs[i].taken});
         chk($sformatf("vec%0d_target", i),  target,             vecs[i].target);
         chk($sformatf("vec%0d_next_pc", i), next_pc,            vecs[i].next_pc);
         step();
         chk($sformatf("vec%0d_flush", i),   {31'd0, flush},     {31'd0, vecs[i].taken});
      end
      chk("vec_count", taken_count, 32'd3);
      step();

      // Back-pressure: two accepts fill the queue, the third waits for a pop.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_req(1'b1, 2'b01, 32'h0000_1000 + 32'(i * 16), 16'(i + 1));
         tick(acc);
         chk($sformatf("bp_accept%0d", i), {31'd0, acc}, (i < 2) ? 32'd1 : 32'd0);
      end
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_head_target", target, 32'h0000_1008);
      step();
      step();
      chk("bp_head_stable", target, 32'h0000_1008);
      out_ready = 1'b1;
      waited    = 0;
      acc       = 1'b0;
      while (!acc && waited < 10) begin
         tick(acc);
         waited++;
      end
      chk("bp_third_accept_cycle", 32'(waited), 32'd2);
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) step();

      // Continuous push+pop: every request accepted, no bubbles.
      in_valid  = 1'b1;
      out_ready = 1'b1;
      n_acc     = 0;
      for (int i = 0; i < 8; i++) begin
         set_rand_req();
         tick(acc);
         if (acc) n_acc++;
         if (i > 0) chk("stream_no_bubble", {31'd0, out_valid}, 32'd1);
      end
      chk("stream_accepts", 32'(n_acc), 32'd8);
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) step();

      // taken_count wrap from all ones.
      out_ready = 1'b0;
      set_req(1'b1, 2'b01, 32'h0000_0500, 16'h0001);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      force dut.taken_count_q = 32'hFFFF_FFFF;
      #1;
      release dut.taken_count_q;
      m_cnt     = 32'hFFFF_FFFF;
      out_ready = 1'b1;
      step();
      step();
      chk("wrap_count", taken_count, 32'd0);

      // Reset with two entries queued and a flush pending.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      set_req(1'b0, 2'b10, 32'h0000_7000, 16'h0003);
      step();
      step();
      step();
      out_ready = 1'b1;
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      in_valid = 1'b0;
      chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("mid_rst_in_ready",  {31'd0, in_ready},  32'd1);
      chk("mid_rst_flush",     {31'd0, flush},     32'd0);
      chk("mid_rst_count",     taken_count,        32'd0);
      for (int i = 0; i < 3; i++) step();

      // Random traffic with occasional resets.
      for (int i = 0; i < 400; i++) begin
         reset     = ($urandom_range(0, 49) == 0);
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 3) != 0);
         set_rand_req();
         step();
      end
      reset    = 1'b0;
      in_valid = 1'b0;
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
